// File: rtl/clkdiv_pkg.sv
// Shared constants and sizing helpers for clock_frequency_divider and clkdiv_counter.
// Both helpers are constant functions, evaluated at elaboration time.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_DEFAULT_INPUT_FREQUENCY = 50_000_000;

    // Returns 0 when out_freq is 0 so that the caller can report the
    // problem with $error instead of hitting a divide-by-zero.
    function automatic int unsigned clkdiv_half_period(input int unsigned in_freq,
                                                       input int unsigned out_freq);
        if (out_freq == 0) begin
            return 0;
        end
        return in_freq / (2 * out_freq);
    endfunction

    function automatic int unsigned clkdiv_counter_width(input int unsigned half_period);
        if (half_period <= 1) begin
            return 1;
        end
        return $clog2(half_period);
    endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Terminal-count counter: counts 0..HALF_PERIOD-1 on InClock.
// wrap is high for the single cycle in which the counter holds HALF_PERIOD-1.
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 10
) (
    input  logic InClock,
    input  logic reset,
    output logic wrap
);

    localparam int unsigned CW = clkdiv_counter_width(HALF_PERIOD);
    localparam logic [CW-1:0] TERMINAL = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_terminal;

    always_comb begin
        at_terminal = (count_q == TERMINAL);
        count_d     = count_q + CW'(1);
        if (at_terminal) begin
            count_d = '0;
        end
    end

    always_ff @(posedge InClock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wrap = at_terminal;

endmodule

// File: rtl/clock_frequency_divider.sv
// Divides InClock down to a registered, 50% duty OutClock of period 2*HALF_PERIOD.
// Define CLKDIV_TICK_EN to add the Tick output (one-cycle pulse after each OutClock rise).
module clock_frequency_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned INPUT_FREQUENCY  = CLKDIV_DEFAULT_INPUT_FREQUENCY,
    parameter int unsigned OUTPUT_FREQUENCY = 1
) (
    input  logic InClock,
    input  logic reset,
    output logic OutClock
`ifdef CLKDIV_TICK_EN
    ,
    output logic Tick
`endif
);

    localparam int unsigned HALF_PERIOD = clkdiv_half_period(INPUT_FREQUENCY, OUTPUT_FREQUENCY);

    if (OUTPUT_FREQUENCY == 0) begin : g_err_zero_out
        $error("clock_frequency_divider: OUTPUT_FREQUENCY must be non-zero");
    end else if (HALF_PERIOD == 0) begin : g_err_too_fast
        $error("clock_frequency_divider: OUTPUT_FREQUENCY exceeds INPUT_FREQUENCY/2");
    end

    logic wrap;
    logic out_q;
    logic out_d;

    clkdiv_counter #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_counter (
        .InClock (InClock),
        .reset   (reset),
        .wrap    (wrap)
    );

    always_comb begin
        out_d = out_q;
        if (wrap) begin
            out_d = ~out_q;
        end
    end

    always_ff @(posedge InClock or posedge reset) begin
        if (reset) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign OutClock = out_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;
    logic tick_d;

    // Registered alongside out_q so Tick covers exactly the first high cycle.
    always_comb begin
        tick_d = wrap & ~out_q;
    end

    always_ff @(posedge InClock or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign Tick = tick_q;
`endif

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Directed bench: HALF_PERIOD=10 (100 Hz -> 5 Hz) and HALF_PERIOD=1 (2 Hz -> 1 Hz).
// Tick checks are compiled in when CLKDIV_TICK_EN is defined.
module tb_clock_frequency_divider;

    logic InClock;
    logic reset;
    logic out_a;
    logic out_b;
`ifdef CLKDIV_TICK_EN
    logic tick_a;
    logic tick_b;
`endif

    int n_vec;
    int n_err;

    clock_frequency_divider #(
        .INPUT_FREQUENCY  (100),
        .OUTPUT_FREQUENCY (5)
    ) u_dut_a (
        .InClock  (InClock),
        .reset    (reset),
        .OutClock (out_a)
`ifdef CLKDIV_TICK_EN
        ,
        .Tick     (tick_a)
`endif
    );

    clock_frequency_divider #(
        .INPUT_FREQUENCY  (2),
        .OUTPUT_FREQUENCY (1)
    ) u_dut_b (
        .InClock  (InClock),
        .reset    (reset),
        .OutClock (out_b)
`ifdef CLKDIV_TICK_EN
        ,
        .Tick     (tick_b)
`endif
    );

    initial begin
        InClock = 1'b0;
        forever #5 InClock = ~InClock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Runs n edges after a reset release; edge k is counted from 1.
    task automatic run_edges(input int n, input bit check_totals);
        int rises_a;
        int ticks_a;
        logic prev_a;
        rises_a = 0;
        ticks_a = 0;
        prev_a  = out_a;
        for (int k = 1; k <= n; k++) begin
            @(posedge InClock);
            #1;
            check($sformatf("out_a_edge%0d", k), {31'b0, out_a}, {31'b0, ((k / 10) % 2) == 1});
            check($sformatf("out_b_edge%0d", k), {31'b0, out_b}, {31'b0, (k % 2) == 1});
`ifdef CLKDIV_TICK_EN
            check($sformatf("tick_a_edge%0d", k), {31'b0, tick_a}, {31'b0, (k % 20) == 10});
            check($sformatf("tick_b_edge%0d", k), {31'b0, tick_b}, {31'b0, (k % 2) == 1});
            if (tick_a) ticks_a++;
`endif
            if (out_a && !prev_a) rises_a++;
            prev_a = out_a;
        end
        if (check_totals) begin
            check("rises_a_200", rises_a, 10);
`ifdef CLKDIV_TICK_EN
            check("ticks_a_200", ticks_a, 10);
`endif
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        repeat (3) @(posedge InClock);
        #1;
        check("reset_out_a", {31'b0, out_a}, 32'd0);
        check("reset_out_b", {31'b0, out_b}, 32'd0);
`ifdef CLKDIV_TICK_EN
        check("reset_tick_a", {31'b0, tick_a}, 32'd0);
        check("reset_tick_b", {31'b0, tick_b}, 32'd0);
`endif
        @(negedge InClock);
        reset = 1'b0;
        run_edges(200, 1'b1);

        // Mid-period reset: release, run 15 edges (out_a high), then assert async.
        reset = 1'b1;
        @(negedge InClock);
        reset = 1'b0;
        run_edges(15, 1'b0);
        check("pre_reset_out_a_high", {31'b0, out_a}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_out_a", {31'b0, out_a}, 32'd0);
        check("async_reset_out_b", {31'b0, out_b}, 32'd0);
        @(posedge InClock);
        #1;
        check("held_reset_out_a", {31'b0, out_a}, 32'd0);
        @(negedge InClock);
        reset = 1'b0;
        run_edges(40, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
